// File: rtl/packet_assembler.sv
// Packs BEATS words read from the async FIFO into one packet held in a
// valid/ready output register, so the next packet can be assembled while the consumer stalls.
module packet_assembler #(
   parameter int IN_W       = 8,
   parameter int BEATS      = 32,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit START_MODE = 1'b0
) (
   input  logic                    rclk,
   input  logic                    rrst,
   input  logic                    fifo_full,
   input  logic                    fifo_empty,
   input  logic [IN_W-1:0]         fifo_data,
   input  logic                    flush,
   input  logic                    packet_ready,
   output logic                    fifo_rd_en,
   output logic [IN_W*BEATS-1:0]   packet_data,
   output logic                    packet_valid,
   output logic                    busy,
   output logic [15:0]             pkt_cnt
);

   localparam int OUT_W = IN_W * BEATS;
   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

   state_t             state, state_next;
   logic               full_s1, full_s2;
   logic [CNT_W-1:0]   issued, captured;
   logic               rd_pend;
   logic [OUT_W-1:0]   asm_reg, asm_next;
   logic               start, capture, load, consume;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         full_s1 <= 1'b0;
         full_s2 <= 1'b0;
      end else begin
         full_s1 <= fifo_full;
         full_s2 <= full_s1;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      fifo_rd_en = 1'b0;
      start      = 1'b0;
      load       = 1'b0;
      capture    = (state == FILL) && rd_pend && !flush;
      consume    = packet_valid && packet_ready;
      case (state)
         IDLE: begin
            if (START_MODE ? !fifo_empty : full_s2) begin
               start      = 1'b1;
               state_next = FILL;
            end
         end
         FILL: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               fifo_rd_en = !fifo_empty && (issued < BEATS_C);
               if (capture && captured == LAST_C) begin
                  if (!packet_valid || packet_ready) begin
                     load       = 1'b1;
                     state_next = IDLE;
                  end else begin
                     state_next = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (flush) begin
               state_next = IDLE;
            end else if (!packet_valid || packet_ready) begin
               load       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // asm_next includes the word captured this cycle, so the last word can go
   // straight into the output register without an extra cycle.
   for (genvar k = 0; k < BEATS; k++) begin : g_slot
      localparam int SLOT = MSB_FIRST ? (BEATS - 1 - k) : k;
      assign asm_next[SLOT*IN_W +: IN_W] = (capture && captured == CNT_W'(k)) ?
                                           fifo_data : asm_reg[SLOT*IN_W +: IN_W];
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         issued   <= '0;
         captured <= '0;
         rd_pend  <= 1'b0;
         asm_reg  <= '0;
      end else begin
         rd_pend <= fifo_rd_en;
         if (start || (flush && state != IDLE)) begin
            issued   <= '0;
            captured <= '0;
            asm_reg  <= '0;
         end else begin
            if (fifo_rd_en) issued <= issued + 1'b1;
            if (capture) begin
               captured <= captured + 1'b1;
               asm_reg  <= asm_next;
            end
         end
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         packet_data  <= '0;
         packet_valid <= 1'b0;
         pkt_cnt      <= '0;
      end else begin
         if (load) begin
            packet_data  <= asm_next;
            packet_valid <= 1'b1;
         end else if (consume) begin
            packet_valid <= 1'b0;
         end
         if (consume) pkt_cnt <= pkt_cnt + 16'd1;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: three BEATS=4 instances (stream MSB, stream LSB,
// burst MSB) share one FIFO model; only the selected instance sees a non-empty FIFO.
module tb_packet_assembler;

   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic        full_drv = 1'b0;
   logic        flush = 1'b0;
   logic        ready = 1'b1;
   logic        gap = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [7:0]  fifo_data = '0;
   logic [2:0]  empty_i;
   logic [2:0]  rd_en;
   logic [31:0] pdata [3];
   logic [2:0]  pvalid;
   logic [2:0]  busyv;
   logic [15:0] cnt [3];

   logic [7:0]  fmem [64];
   logic [5:0]  rp = '0;
   logic [5:0]  wp = '0;
   int          rd_cnt = 0;
   int          underflow = 0;
   logic        model_empty, cur_rd, cur_valid;
   logic [31:0] cur_data;

   int total = 0;
   int bad = 0;

   always #5 rclk = ~rclk;

   packet_assembler #(.IN_W(8), .BEATS(4), .MSB_FIRST(1'b1), .START_MODE(1'b1)) u_msb (
      .rclk(rclk), .rrst(rrst), .fifo_full(full_drv), .fifo_empty(empty_i[0]),
      .fifo_data(fifo_data), .flush(flush), .packet_ready(ready), .fifo_rd_en(rd_en[0]),
      .packet_data(pdata[0]), .packet_valid(pvalid[0]), .busy(busyv[0]), .pkt_cnt(cnt[0]));

   packet_assembler #(.IN_W(8), .BEATS(4), .MSB_FIRST(1'b0), .START_MODE(1'b1)) u_lsb (
      .rclk(rclk), .rrst(rrst), .fifo_full(full_drv), .fifo_empty(empty_i[1]),
      .fifo_data(fifo_data), .flush(flush), .packet_ready(ready), .fifo_rd_en(rd_en[1]),
      .packet_data(pdata[1]), .packet_valid(pvalid[1]), .busy(busyv[1]), .pkt_cnt(cnt[1]));

   packet_assembler #(.IN_W(8), .BEATS(4), .MSB_FIRST(1'b1), .START_MODE(1'b0)) u_burst (
      .rclk(rclk), .rrst(rrst), .fifo_full(full_drv), .fifo_empty(empty_i[2]),
      .fifo_data(fifo_data), .flush(flush), .packet_ready(ready), .fifo_rd_en(rd_en[2]),
      .packet_data(pdata[2]), .packet_valid(pvalid[2]), .busy(busyv[2]), .pkt_cnt(cnt[2]));

   assign model_empty = (rp == wp) || gap;
   assign empty_i[0]  = model_empty || (sel != 2'd0);
   assign empty_i[1]  = model_empty || (sel != 2'd1);
   assign empty_i[2]  = model_empty || (sel != 2'd2);
   assign cur_rd      = rd_en[sel];
   assign cur_valid   = pvalid[sel];
   assign cur_data    = pdata[sel];

   // Read data appears one cycle after the accepted read.
   always @(posedge rclk) begin
      if (cur_rd) begin
         rd_cnt <= rd_cnt + 1;
         if (rp == wp) underflow <= underflow + 1;
         else begin
            fifo_data <= fmem[rp];
            rp        <= rp + 6'd1;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      fmem[wp] = w;
      wp       = wp + 6'd1;
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic watch(input int ncyc, input int gs, input int gl,
                        output int first, output int nv, output logic [31:0] d,
                        output int gap_rd);
      first  = -1;
      nv     = 0;
      d      = '0;
      gap_rd = 0;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         gap = (c >= gs) && (c < gs + gl);
         #1;
         if (cur_valid) begin
            if (first < 0) begin
               first = c;
               d     = cur_data;
            end
            nv++;
         end
         if (gap && cur_rd) gap_rd++;
      end
      gap = 1'b0;
   endtask

   initial begin
      int first, nv, gap_rd, r0, hold_bad;
      logic [31:0] d;

      repeat (3) @(posedge rclk);
      #1;
      check_val("rst_rd_en", 32'(rd_en), 32'd0);
      check_val("rst_valid", 32'(pvalid), 32'd0);
      check_val("rst_busy", 32'(busyv), 32'd0);
      check_val("rst_data", pdata[0], 32'd0);
      check_val("rst_cnt", 32'(cnt[0]), 32'd0);
      rrst = 1'b0;
      tick();

      // Stream, MSB first
      sel = 2'd0; ready = 1'b1; r0 = rd_cnt;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      watch(12, 99, 0, first, nv, d, gap_rd);
      check_val("msb_first_cyc", 32'(first), 32'd6);
      check_val("msb_nvalid", 32'(nv), 32'd1);
      check_val("msb_data", d, 32'h11223344);
      check_val("msb_reads", 32'(rd_cnt - r0), 32'd4);
      check_val("msb_cnt", 32'(cnt[0]), 32'd1);
      check_val("msb_busy_end", 32'(busyv[0]), 32'd0);

      // Stream, LSB first
      sel = 2'd1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      watch(12, 99, 0, first, nv, d, gap_rd);
      check_val("lsb_first_cyc", 32'(first), 32'd6);
      check_val("lsb_data", d, 32'h44332211);
      check_val("lsb_cnt", 32'(cnt[1]), 32'd1);

      // Empty gap of 3 cycles after word 2
      sel = 2'd0;
      push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
      watch(14, 3, 3, first, nv, d, gap_rd);
      check_val("gap_first_cyc", 32'(first), 32'd9);
      check_val("gap_nvalid", 32'(nv), 32'd1);
      check_val("gap_data", d, 32'hA1B2C3D4);
      check_val("gap_reads", 32'(gap_rd), 32'd0);

      // Burst: full held, consumer stalled for 20 cycles
      sel = 2'd2; ready = 1'b0; r0 = rd_cnt; first = -1; hold_bad = 0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      full_drv = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         full_drv = (c <= 6);
         #1;
         if (c <= 20) begin
            if (cur_valid && first < 0) first = c;
            if (c >= 8 && (!cur_valid || cur_data != 32'h01020304)) hold_bad++;
         end
         if (c == 20) begin
            check_val("burst_first_cyc", 32'(first), 32'd8);
            check_val("burst_hold_stable", 32'(hold_bad), 32'd0);
            check_val("burst_in_hold", 32'(busyv[2]), 32'd1);
            check_val("burst_reads", 32'(rd_cnt - r0), 32'd8);
            ready = 1'b1;
         end
         if (c == 21) begin
            check_val("burst_b2b_valid", 32'(cur_valid), 32'd1);
            check_val("burst_b2b_data", cur_data, 32'h05060708);
            check_val("burst_idle", 32'(busyv[2]), 32'd0);
         end
         if (c == 22) begin
            check_val("burst_valid_drop", 32'(cur_valid), 32'd0);
            check_val("burst_cnt", 32'(cnt[2]), 32'd2);
         end
      end

      // Flush after two captures
      sel = 2'd0; ready = 1'b1;
      push(8'hC1); push(8'hC2);
      tick(); tick(); tick();
      tick();
      push(8'hC3); push(8'hC4); push(8'hC5); push(8'hC6);
      flush = 1'b1;
      #1;
      check_val("flush_rd_en", 32'(cur_rd), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check_val("flush_idle", 32'(busyv[0]), 32'd0);
      watch(10, 99, 0, first, nv, d, gap_rd);
      check_val("flush_first_cyc", 32'(first), 32'd6);
      check_val("flush_data", d, 32'hC3C4C5C6);
      check_val("flush_cnt", 32'(cnt[0]), 32'd3);

      // Asynchronous reset mid-FILL
      push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
      tick(); tick();
      #2 rrst = 1'b1;
      #1;
      check_val("arst_busy", 32'(busyv[0]), 32'd0);
      check_val("arst_rd_en", 32'(rd_en[0]), 32'd0);
      check_val("arst_data", pdata[0], 32'd0);
      check_val("arst_cnt", 32'(cnt[0]), 32'd0);
      tick();
      rrst = 1'b0;
      watch(10, 99, 0, first, nv, d, gap_rd);
      check_val("arst_no_stray", 32'(nv), 32'd0);
      check_val("no_overread", 32'(underflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
